// File: rtl/cnet_reprogram_ctrl.sv
// SelectMAP master that reprograms the CNET FPGA from a host byte stream.
// Define CNET_PROG_BYTE_CNT_EN to add the bytes_written output and its counter.
module cnet_reprogram_ctrl #(
    parameter int CCLK_DIV     = 2,
    parameter int PROG_B_CCLKS = 16,
    parameter int INIT_TIMEOUT = 4096,
    parameter int DONE_TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [7:0]  data_in,
    input  logic        data_valid,
    input  logic        data_last,
    output logic        data_ready,
    output logic        busy,
    output logic        done_ok,
    output logic        error,
    output logic [1:0]  error_code,
    output logic        rp_prog_b,
    input  logic        rp_init_b,
    output logic        rp_cs_b,
    output logic        rp_rdwr_b,
    output logic [7:0]  rp_data,
    input  logic        rp_done,
    output logic        rp_cclk,
`ifdef CNET_PROG_BYTE_CNT_EN
    output logic [23:0] bytes_written,
`endif
    output logic [2:0]  dbg_state
);

    localparam int MAX_A = (PROG_B_CCLKS > INIT_TIMEOUT) ? PROG_B_CCLKS : INIT_TIMEOUT;
    localparam int MAX_T = (MAX_A > DONE_TIMEOUT) ? MAX_A : DONE_TIMEOUT;
    localparam int CW    = $clog2(MAX_T) + 1;
    localparam int DW    = $clog2(CCLK_DIV) + 1;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_PROG      = 3'd1,
        S_WAIT_INIT = 3'd2,
        S_LOAD      = 3'd3,
        S_LAST      = 3'd4,
        S_WAIT_DONE = 3'd5,
        S_ERR       = 3'd6
    } state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] div_q;
    logic          cclk_q;
    logic          div_tc;
    logic          fall_en;
    logic [1:0]    init_sync_q;
    logic [1:0]    done_sync_q;
    logic          init_s;
    logic          done_s;
    logic          prog_b_q, prog_b_d;
    logic          cs_b_q, cs_b_d;
    logic          rdwr_b_q, rdwr_b_d;
    logic [7:0]    data_q, data_d;
    logic          error_q, error_d;
    logic [1:0]    code_q, code_d;
    logic [CW-1:0] tcnt_q, tcnt_d;
    logic          seen_low_q, seen_low_d;
    logic          done_ok_q, done_ok_d;
    logic          ready_d;

    // Free-running CCLK divider; the strobes mark the clk cycle before each edge.
    assign div_tc  = (div_q == DW'(CCLK_DIV - 1));
    assign fall_en = div_tc & cclk_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_q  <= '0;
            cclk_q <= 1'b0;
        end else if (div_tc) begin
            div_q  <= '0;
            cclk_q <= ~cclk_q;
        end else begin
            div_q  <= div_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            init_sync_q <= 2'b00;
            done_sync_q <= 2'b00;
        end else begin
            init_sync_q <= {init_sync_q[0], rp_init_b};
            done_sync_q <= {done_sync_q[0], rp_done};
        end
    end

    assign init_s = init_sync_q[1];
    assign done_s = done_sync_q[1];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            prog_b_q   <= 1'b1;
            cs_b_q     <= 1'b1;
            rdwr_b_q   <= 1'b1;
            data_q     <= 8'h00;
            error_q    <= 1'b0;
            code_q     <= 2'd0;
            tcnt_q     <= '0;
            seen_low_q <= 1'b0;
            done_ok_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            prog_b_q   <= prog_b_d;
            cs_b_q     <= cs_b_d;
            rdwr_b_q   <= rdwr_b_d;
            data_q     <= data_d;
            error_q    <= error_d;
            code_q     <= code_d;
            tcnt_q     <= tcnt_d;
            seen_low_q <= seen_low_d;
            done_ok_q  <= done_ok_d;
        end
    end

    // Byte handshake: a byte moves in the clk cycle where data_valid and data_ready
    // are both high; data_ready is raised only on a fall_en in LOAD, and data_in must
    // be held stable while data_valid is high and data_ready has not yet been seen.
    always_comb begin
        state_d    = state_q;
        prog_b_d   = prog_b_q;
        cs_b_d     = cs_b_q;
        rdwr_b_d   = rdwr_b_q;
        data_d     = data_q;
        error_d    = error_q;
        code_d     = code_q;
        tcnt_d     = tcnt_q;
        seen_low_d = seen_low_q;
        done_ok_d  = 1'b0;
        ready_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_PROG;
                    error_d    = 1'b0;
                    code_d     = 2'd0;
                    tcnt_d     = '0;
                    seen_low_d = 1'b0;
                end
            end
            S_PROG: begin
                if (!init_s) seen_low_d = 1'b1;
                if (fall_en) begin
                    if (prog_b_q) begin
                        prog_b_d = 1'b0;
                        tcnt_d   = '0;
                    end else if (tcnt_q == CW'(PROG_B_CCLKS - 1)) begin
                        prog_b_d = 1'b1;
                        rdwr_b_d = 1'b0;
                        tcnt_d   = '0;
                        state_d  = S_WAIT_INIT;
                    end else begin
                        tcnt_d = tcnt_q + 1'b1;
                    end
                end
            end
            S_WAIT_INIT: begin
                if (!init_s) seen_low_d = 1'b1;
                if (seen_low_q && init_s) begin
                    state_d = S_LOAD;
                end else if (fall_en) begin
                    if (tcnt_q == CW'(INIT_TIMEOUT - 1)) begin
                        state_d = S_ERR;
                        code_d  = 2'd1;
                    end else begin
                        tcnt_d = tcnt_q + 1'b1;
                    end
                end
            end
            S_LOAD: begin
                if (fall_en) begin
                    if (!init_s) begin
                        // Drop chip select now so the held byte is not written twice.
                        cs_b_d  = 1'b1;
                        state_d = S_ERR;
                        code_d  = 2'd2;
                    end else if (data_valid) begin
                        data_d  = data_in;
                        cs_b_d  = 1'b0;
                        ready_d = 1'b1;
                        if (data_last) state_d = S_LAST;
                    end else begin
                        cs_b_d = 1'b1;
                    end
                end
            end
            S_LAST: begin
                if (fall_en) begin
                    cs_b_d  = 1'b1;
                    tcnt_d  = '0;
                    state_d = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                if (fall_en) begin
                    if (done_s) begin
                        rdwr_b_d  = 1'b1;
                        done_ok_d = 1'b1;
                        state_d   = S_IDLE;
                    end else if (tcnt_q == CW'(DONE_TIMEOUT - 1)) begin
                        state_d = S_ERR;
                        code_d  = 2'd3;
                    end else begin
                        tcnt_d = tcnt_q + 1'b1;
                    end
                end
            end
            S_ERR: begin
                if (fall_en) begin
                    cs_b_d   = 1'b1;
                    rdwr_b_d = 1'b1;
                    error_d  = 1'b1;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

`ifdef CNET_PROG_BYTE_CNT_EN
    logic        rise_en;
    logic [23:0] bcnt_q;

    assign rise_en = div_tc & ~cclk_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bcnt_q <= 24'h000000;
        end else if ((state_q == S_IDLE) && start) begin
            bcnt_q <= 24'h000000;
        end else if (rise_en && !cs_b_q && (bcnt_q != 24'hFFFFFF)) begin
            bcnt_q <= bcnt_q + 24'h000001;
        end
    end

    assign bytes_written = bcnt_q;
`endif

    assign data_ready = ready_d;
    assign busy       = (state_q != S_IDLE);
    assign done_ok    = done_ok_q;
    assign error      = error_q;
    assign error_code = code_q;
    assign rp_prog_b  = prog_b_q;
    assign rp_cs_b    = cs_b_q;
    assign rp_rdwr_b  = rdwr_b_q;
    assign rp_data    = data_q;
    assign rp_cclk    = cclk_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_cnet_reprogram_ctrl.sv
// Directed bench for cnet_reprogram_ctrl with a small behavioural CNET SelectMAP target.
module tb_cnet_reprogram_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  data_in = 8'h00;
  logic        data_valid = 1'b0;
  logic        data_last = 1'b0;
  logic        data_ready;
  logic        busy;
  logic        done_ok;
  logic        error;
  logic [1:0]  error_code;
  logic        rp_prog_b;
  logic        rp_init_b = 1'b1;
  logic        rp_cs_b;
  logic        rp_rdwr_b;
  logic [7:0]  rp_data;
  logic        rp_done = 1'b0;
  logic        rp_cclk;
  logic [2:0]  dbg_state;
`ifdef CNET_PROG_BYTE_CNT_EN
  logic [23:0] bytes_written;
`endif

  int checks = 0;
  int passed = 0;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];

  // CNET model state
  int   wr_cnt = 0;
  int   rdwr_viol = 0;
  int   init_dly = 0;
  bit   want_crc_error = 1'b0;
  bit   tie_init_low = 1'b0;
  bit   crc_hold = 1'b0;
  logic prev_cclk = 1'b0;

  cnet_reprogram_ctrl #(
    .CCLK_DIV(2), .PROG_B_CCLKS(16), .INIT_TIMEOUT(64), .DONE_TIMEOUT(32)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .data_in(data_in), .data_valid(data_valid), .data_last(data_last),
    .data_ready(data_ready), .busy(busy), .done_ok(done_ok),
    .error(error), .error_code(error_code),
    .rp_prog_b(rp_prog_b), .rp_init_b(rp_init_b), .rp_cs_b(rp_cs_b),
    .rp_rdwr_b(rp_rdwr_b), .rp_data(rp_data), .rp_done(rp_done), .rp_cclk(rp_cclk),
`ifdef CNET_PROG_BYTE_CNT_EN
    .bytes_written(bytes_written),
`endif
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d passed %0d", checks, passed);
    $fatal(1, "watchdog");
  end

  // CNET target: samples one byte per rising CCLK while CS_B is low, expects 16 bytes.
  always @(posedge clk) begin
    if (!rp_prog_b) begin
      rp_init_b = 1'b0;
      rp_done   = 1'b0;
      wr_cnt    = 0;
      crc_hold  = 1'b0;
      init_dly  = 0;
    end else begin
      if (!rp_init_b && !tie_init_low && !crc_hold) begin
        init_dly++;
        if (init_dly >= 20) rp_init_b = 1'b1;
      end
      if (rp_cclk && !prev_cclk && !rp_cs_b) begin
        if (rp_rdwr_b) rdwr_viol++;
        got_q.push_back(rp_data);
        wr_cnt++;
        if (want_crc_error) begin
          crc_hold  = 1'b1;
          rp_init_b = 1'b0;
        end
        if (wr_cnt == 16) rp_done = 1'b1;
      end
    end
    prev_cclk = rp_cclk;
  end

  // driver tasks
  task automatic do_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic stream(input int n, input bit gaps, input int seed,
                        output int readies, output int gap_cnt);
    bit got;
    int t;
    readies = 0;
    gap_cnt = 0;
    for (int i = 0; i < n; i++) begin
      data_in    = 8'((i * 37 + seed) & 255);
      data_valid = 1'b1;
      data_last  = (i == n - 1);
      got = 1'b0;
      t = 0;
      while (!got && t < 200) begin
        @(negedge clk);
        t++;
        if (data_ready) got = 1'b1;
        else if (!busy) t = 200;
      end
      if (!got) begin
        data_valid = 1'b0;
        data_last  = 1'b0;
        return;
      end
      exp_q.push_back(data_in);
      readies++;
      @(posedge clk); #1;
      if (gaps && i != n - 1) begin
        data_valid = 1'b0;
        data_last  = 1'b0;
        t = 0;
        while (t < 50) begin
          @(negedge clk);
          t++;
          if (rp_cs_b) begin
            gap_cnt++;
            t = 50;
          end
        end
      end
    end
    data_valid = 1'b0;
    data_last  = 1'b0;
  endtask

  task automatic wait_idle(output bit saw_done);
    int t;
    saw_done = 1'b0;
    t = 0;
    while (t < 3000) begin
      @(negedge clk);
      t++;
      if (done_ok) saw_done = 1'b1;
      if (!busy) t = 3000;
    end
  endtask

  task automatic clear_sb();
    exp_q.delete();
    got_q.delete();
    rdwr_viol = 0;
  endtask

  function automatic int data_bad();
    int bad;
    bad = 0;
    if (got_q.size() != exp_q.size()) bad++;
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      if (got_q[i] !== exp_q[i]) bad++;
    return bad;
  endfunction

  // scenarios
  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (rp_prog_b !== 1'b1) $display("FAIL reset_prog_b: got %b want 1", rp_prog_b); else passed++;
    checks++; if (rp_cs_b !== 1'b1) $display("FAIL reset_cs_b: got %b want 1", rp_cs_b); else passed++;
    checks++; if (rp_rdwr_b !== 1'b1) $display("FAIL reset_rdwr_b: got %b want 1", rp_rdwr_b); else passed++;
    checks++; if (rp_data !== 8'h00) $display("FAIL reset_data: got %h want 00", rp_data); else passed++;
    checks++; if (rp_cclk !== 1'b0) $display("FAIL reset_cclk: got %b want 0", rp_cclk); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passed++;
    checks++; if (data_ready !== 1'b0) $display("FAIL reset_ready: got %b want 0", data_ready); else passed++;
    checks++; if (done_ok !== 1'b0) $display("FAIL reset_done_ok: got %b want 0", done_ok); else passed++;
    checks++; if (error !== 1'b0) $display("FAIL reset_error: got %b want 0", error); else passed++;
    checks++; if (error_code !== 2'd0) $display("FAIL reset_code: got %0d want 0", error_code); else passed++;
    checks++; if (dbg_state !== 3'd0) $display("FAIL reset_state: got %0d want 0", dbg_state); else passed++;
    @(negedge clk) reset_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int n, t, readies, gaps;
    bit saw;
    clear_sb();
    do_start();
    @(negedge clk);
    checks++; if (busy !== 1'b1) $display("FAIL b2b_busy: got %b want 1", busy); else passed++;
    t = 0;
    while (rp_prog_b && t < 100) begin @(negedge clk); t++; end
    n = 0;
    while (!rp_prog_b && n < 500) begin @(negedge clk); n++; end
    checks++; if (n != 64) $display("FAIL b2b_prog_width: got %0d clk want 64", n); else passed++;
    stream(16, 1'b0, 3, readies, gaps);
    wait_idle(saw);
    checks++; if (readies != 16) $display("FAIL b2b_readies: got %0d want 16", readies); else passed++;
    checks++; if (saw !== 1'b1) $display("FAIL b2b_done_ok: got %b want 1", saw); else passed++;
    checks++; if (error !== 1'b0) $display("FAIL b2b_error: got %b want 0", error); else passed++;
    checks++; if (data_bad() != 0) $display("FAIL b2b_data: got %0d bad bytes (%0d written) want 0", data_bad(), got_q.size()); else passed++;
    checks++; if (rdwr_viol != 0) $display("FAIL b2b_rdwr: got %0d violations want 0", rdwr_viol); else passed++;
    checks++; if (rp_rdwr_b !== 1'b1) $display("FAIL b2b_rdwr_idle: got %b want 1", rp_rdwr_b); else passed++;
    checks++; if (rp_cs_b !== 1'b1) $display("FAIL b2b_cs_idle: got %b want 1", rp_cs_b); else passed++;
`ifdef CNET_PROG_BYTE_CNT_EN
    checks++; if (bytes_written !== 24'd16) $display("FAIL b2b_bytes: got %0d want 16", bytes_written); else passed++;
`endif
  endtask

  task automatic test_gaps();
    int readies, gaps;
    bit saw;
    clear_sb();
    do_start();
    stream(16, 1'b1, 11, readies, gaps);
    wait_idle(saw);
    checks++; if (readies != 16) $display("FAIL gap_readies: got %0d want 16", readies); else passed++;
    checks++; if (gaps != 15) $display("FAIL gap_cs_high: got %0d gaps want 15", gaps); else passed++;
    checks++; if (got_q.size() != 16) $display("FAIL gap_writes: got %0d want 16", got_q.size()); else passed++;
    checks++; if (data_bad() != 0) $display("FAIL gap_data: got %0d bad bytes want 0", data_bad()); else passed++;
    checks++; if (saw !== 1'b1) $display("FAIL gap_done_ok: got %b want 1", saw); else passed++;
    checks++; if (rdwr_viol != 0) $display("FAIL gap_rdwr: got %0d violations want 0", rdwr_viol); else passed++;
    checks++; if (error !== 1'b0) $display("FAIL gap_error: got %b want 0", error); else passed++;
  endtask

  task automatic test_crc_error();
    int readies, gaps;
    bit saw;
    clear_sb();
    want_crc_error = 1'b1;
    do_start();
    stream(16, 1'b0, 29, readies, gaps);
    wait_idle(saw);
    want_crc_error = 1'b0;
    checks++; if (error !== 1'b1) $display("FAIL crc_error: got %b want 1", error); else passed++;
    checks++; if (error_code !== 2'd2) $display("FAIL crc_code: got %0d want 2", error_code); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL crc_busy: got %b want 0", busy); else passed++;
    checks++; if (rp_cs_b !== 1'b1) $display("FAIL crc_cs_b: got %b want 1", rp_cs_b); else passed++;
    checks++; if (saw !== 1'b0) $display("FAIL crc_no_done: got %b want 0", saw); else passed++;
  endtask

  task automatic test_init_timeout();
    int n, t;
    bit saw;
    tie_init_low = 1'b1;
    do_start();
    t = 0;
    while (rp_prog_b && t < 100) begin @(negedge clk); t++; end
    t = 0;
    while (!rp_prog_b && t < 500) begin @(negedge clk); t++; end
    n = 0;
    while (error_code != 2'd1 && n < 1000) begin @(negedge clk); n++; end
    checks++; if (n != 256) $display("FAIL init_to_latency: got %0d clk want 256", n); else passed++;
    wait_idle(saw);
    tie_init_low = 1'b0;
    checks++; if (error !== 1'b1) $display("FAIL init_to_error: got %b want 1", error); else passed++;
    checks++; if (error_code !== 2'd1) $display("FAIL init_to_code: got %0d want 1", error_code); else passed++;
    checks++; if (rp_prog_b !== 1'b1) $display("FAIL init_to_prog_b: got %b want 1", rp_prog_b); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL init_to_busy: got %b want 0", busy); else passed++;
  endtask

  task automatic test_done_timeout();
    int n, t, readies, gaps;
    bit saw;
    clear_sb();
    do_start();
    checks++; if (error !== 1'b0) $display("FAIL done_to_error_cleared: got %b want 0", error); else passed++;
    stream(15, 1'b0, 47, readies, gaps);
    t = 0;
    while (!rp_cs_b && t < 100) begin @(negedge clk); t++; end
    n = 0;
    while (error_code != 2'd3 && n < 1000) begin @(negedge clk); n++; end
    checks++; if (n != 128) $display("FAIL done_to_latency: got %0d clk want 128", n); else passed++;
    wait_idle(saw);
    checks++; if (readies != 15) $display("FAIL done_to_readies: got %0d want 15", readies); else passed++;
    checks++; if (error !== 1'b1) $display("FAIL done_to_error: got %b want 1", error); else passed++;
    checks++; if (error_code !== 2'd3) $display("FAIL done_to_code: got %0d want 3", error_code); else passed++;
    checks++; if (saw !== 1'b0) $display("FAIL done_to_no_done: got %b want 0", saw); else passed++;
`ifdef CNET_PROG_BYTE_CNT_EN
    checks++; if (bytes_written !== 24'd15) $display("FAIL done_to_bytes: got %0d want 15", bytes_written); else passed++;
`endif
  endtask

  task automatic test_reset_mid_load();
    int cnt, t, readies, gaps;
    bit saw;
    clear_sb();
    do_start();
    data_in    = 8'h5A;
    data_valid = 1'b1;
    data_last  = 1'b0;
    cnt = 0;
    t = 0;
    while (cnt < 3 && t < 1000) begin
      @(negedge clk);
      t++;
      if (data_ready) cnt++;
    end
    checks++; if (cnt != 3) $display("FAIL rst_reach_load: got %0d bytes want 3", cnt); else passed++;
    checks++; if (dbg_state !== 3'd3) $display("FAIL rst_in_load: got state %0d want 3", dbg_state); else passed++;
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    checks++; if (rp_prog_b !== 1'b1) $display("FAIL rst_prog_b: got %b want 1", rp_prog_b); else passed++;
    checks++; if (rp_cs_b !== 1'b1) $display("FAIL rst_cs_b: got %b want 1", rp_cs_b); else passed++;
    checks++; if (rp_rdwr_b !== 1'b1) $display("FAIL rst_rdwr_b: got %b want 1", rp_rdwr_b); else passed++;
    checks++; if (rp_data !== 8'h00) $display("FAIL rst_data: got %h want 00", rp_data); else passed++;
    checks++; if (rp_cclk !== 1'b0) $display("FAIL rst_cclk: got %b want 0", rp_cclk); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else passed++;
    checks++; if (data_ready !== 1'b0) $display("FAIL rst_ready: got %b want 0", data_ready); else passed++;
    checks++; if (error !== 1'b0 || error_code !== 2'd0) $display("FAIL rst_error: got %b/%0d want 0/0", error, error_code); else passed++;
    data_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    clear_sb();
    do_start();
    stream(16, 1'b0, 101, readies, gaps);
    wait_idle(saw);
    checks++; if (readies != 16) $display("FAIL rst_reload_readies: got %0d want 16", readies); else passed++;
    checks++; if (saw !== 1'b1) $display("FAIL rst_reload_done_ok: got %b want 1", saw); else passed++;
    checks++; if (data_bad() != 0) $display("FAIL rst_reload_data: got %0d bad bytes want 0", data_bad()); else passed++;
    checks++; if (error !== 1'b0) $display("FAIL rst_reload_error: got %b want 0", error); else passed++;
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_gaps();
    test_crc_error();
    test_init_timeout();
    test_done_timeout();
    test_reset_mid_load();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
